// File: rtl/serial_adder.sv
// Bit-serial full adder: one full-adder cell plus a carry flop, LSB first, start/busy/done handshake.
// Optional subtract mode (B inverted before the cell) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic [1:0]       o_state
);

  // Handshake: i_start is sampled only in IDLE; o_busy is high for the WIDTH
  // RUN cycles; o_done pulses for one cycle once o_sum/o_carry hold the result.
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;
  logic load, step, finish;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             b_bit;
  logic             sum_bit;
  logic             carry_next;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sub_q <= 1'b0;
    end else if (load) begin
      sub_q <= i_sub;
    end
  end

  assign b_bit = b_sr[0] ^ sub_q;
`else
  assign b_bit = b_sr[0];
`endif

  assign sum_bit    = a_sr[0] ^ b_bit ^ carry_q;
  assign carry_next = (a_sr[0] & b_bit) | (a_sr[0] & carry_q) | (b_bit & carry_q);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands shift right so bit k always sits at position 0; results enter MSB-side.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      cnt     <= '0;
      carry_q <= 1'b0;
      o_sum   <= '0;
      o_carry <= 1'b0;
    end else if (load) begin
      a_sr    <= i_a;
      b_sr    <= i_b;
      carry_q <= i_carry_in;
      cnt     <= '0;
    end else if (step) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr  <= {sum_bit, res_sr[WIDTH-1:1]};
      carry_q <= carry_next;
      cnt     <= cnt + 1'b1;
      if (finish) begin
        o_sum   <= {sum_bit, res_sr[WIDTH-1:1]};
        o_carry <= carry_next;
      end
    end
  end

  assign o_busy  = (state == RUN);
  assign o_done  = (state == DONE);
  assign o_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): latency, arithmetic, ignored start,
// abort by reset, back-to-back operation and, when enabled, subtract mode.
module tb_serial_adder;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 40;

  logic             i_clk;
  logic             i_reset;
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_carry_in;
  logic             i_sub;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic [1:0]       o_state;

  int checks;
  int failures;
  logic [WIDTH-1:0] prev_sum;
  logic             prev_carry;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_carry_in (i_carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub      (i_sub),
`endif
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_sum      (o_sum),
    .o_carry    (o_carry),
    .o_state    (o_state)
  );

  // clock / reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts one operation and follows it to o_done. pulse_at >= 0 re-asserts i_start
  // with different operands in that RUN sample, which must be ignored.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub, input logic [7:0] exp_sum,
                        input logic exp_carry, input int pulse_at);
    int n;
    int busy_cnt;
    i_a = a; i_b = b; i_carry_in = cin; i_sub = sub; i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_a = 8'($urandom_range(0, 255));
    i_b = 8'($urandom_range(0, 255));
    i_carry_in = 1'($urandom_range(0, 1));
    i_sub = ~sub;
    n = 0;
    busy_cnt = 0;
    while (!o_done && n < TIMEOUT) begin
      if (o_busy) busy_cnt++;
      check({tag, "_hold_sum"}, 32'(o_sum), 32'(prev_sum));
      if (n == pulse_at) begin
        i_a = 8'hAA; i_b = 8'h55; i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      step();
      n++;
    end
    i_start = 1'b0;
    check({tag, "_done_latency"}, 32'(n), 32'(WIDTH));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
    check({tag, "_sum"}, 32'(o_sum), 32'(exp_sum));
    check({tag, "_carry"}, 32'(o_carry), 32'(exp_carry));
    check({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
    prev_sum = exp_sum;
    prev_carry = exp_carry;
    step();
    check({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
    check({tag, "_idle_after"}, 32'(o_state), 32'd0);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int dones;
    int busys;
    dones = 0;
    busys = 0;
    for (int i = 0; i < cycles; i++) begin
      if (o_done) dones++;
      if (o_busy) busys++;
      step();
    end
    check({tag, "_no_extra_done"}, 32'(dones), 32'd0);
    check({tag, "_no_extra_busy"}, 32'(busys), 32'd0);
    check({tag, "_sum_held"}, 32'(o_sum), 32'(prev_sum));
    check({tag, "_carry_held"}, 32'(o_carry), 32'(prev_carry));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    prev_sum = '0;
    prev_carry = 1'b0;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_a = '0;
    i_b = '0;
    i_carry_in = 1'b0;
    i_sub = 1'b0;
    step();
    step();
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_sum", 32'(o_sum), 32'd0);
    check("reset_carry", 32'(o_carry), 32'd0);
    check("reset_state", 32'(o_state), 32'd0);
    i_reset = 1'b0;
    step();
    check("idle_no_start", 32'(o_busy), 32'd0);

    run_op("add_1_1", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, -1);
    run_op("add_ff_1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, -1);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, -1);
    run_op("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, -1);

    // a start pulse in the third RUN cycle must be dropped, not queued
    run_op("ignore_start", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 2);
    quiet_window("ignore_start", 12);

    // abort: reset asserted during the fourth RUN cycle
    i_a = 8'h12; i_b = 8'h34; i_carry_in = 1'b0; i_sub = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    step();
    step();
    check("abort_busy_before", 32'(o_busy), 32'd1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_sum", 32'(o_sum), 32'd0);
    check("abort_carry", 32'(o_carry), 32'd0);
    prev_sum = '0;
    prev_carry = 1'b0;
    quiet_window("abort", 12);
    run_op("after_abort", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, -1);

    // back-to-back: second start lands on the earliest accepting edge
    run_op("b2b_first", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, -1);
    run_op("b2b_second", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, -1);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_5_7", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, -1);
    run_op("sub_7_5", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, -1);
    run_op("sub_off", 8'h07, 8'h05, 1'b0, 1'b0, 8'h0C, 1'b0, -1);
`endif

    quiet_window("final", 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial full adder; successor to the single-bit combinational half adder.
- Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Uses a start/busy/done handshake.
- Sits behind switch/register inputs in the arithmetic datapath, where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_reset  input  1  synchronous active-high reset.
- i_start  input  1  request a new addition; sampled only in IDLE.
- i_a  input  WIDTH  operand A; captured on accepted start.
- i_b  input  WIDTH  operand B; captured on accepted start.
- i_carry_in  input  1  carry-in; captured on accepted start.
- o_busy  output  1  high while bits are being processed (RUN).
- o_done  output  1  one-cycle pulse when the result is valid.
- o_sum  output  WIDTH  result; held until the next completion.
- o_carry  output  1  final carry-out; held with o_sum.

Behaviour:
- Reset: on rising edge with i_reset=1, state←IDLE, bit counter←0, internal operand/carry registers←0, o_busy=0, o_done=0, o_sum=0, o_carry=0. Reset has priority over all other inputs.
- States:
  - IDLE: i_start=1 at edge T0 → load A and B shift registers and carry←i_carry_in, counter←0, go RUN. i_start=0 → stay.
  - RUN: each edge processes bit k=counter. Sum bit s=a[k]^b[k]^c and carry←majority(a[k],b[k],c). s is shifted into the result shift register MSB-side, and counter increments. On the edge processing k=WIDTH-1 (edge T0+WIDTH), o_sum←full result, o_carry←final carry, go DONE.
  - DONE: o_done=1 for exactly this one cycle, then next edge → IDLE unconditionally.
- Latency: o_busy high in cycles after T0 through T0+WIDTH. o_done high in the cycle after edge T0+WIDTH. Earliest next start accepted at edge T0+WIDTH+2.
- Outputs are registered; no combinational path from inputs to outputs.
- i_start in RUN or DONE is ignored, with no queuing. i_a, i_b and i_carry_in may change freely after acceptance without affecting the result.
- o_sum and o_carry are updated only at completion; intermediate shift states are never visible on o_sum.
- Arithmetic: {o_carry,o_sum} = i_a + i_b + i_carry_in, exact modulo 2^(WIDTH+1). Wrap-around example: all-ones + 1 gives o_sum=0, o_carry=1.
- Reset mid-operation aborts the operation. No o_done is emitted, and o_sum/o_carry return to 0.
- Counter width is clog2(WIDTH), sized by the parameter; no hard-coded widths.

Optional Feature:
- SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port i_sub (input, 1), captured on accepted start alongside the operands.
  - When captured i_sub=1, the B bits are inverted before the full-adder cell, so the result is i_a + ~i_b + i_carry_in. Plain subtraction uses i_carry_in=1.
  - o_carry=1 means no borrow.
- Undefined: no i_sub port; the block is add-only and behaviour is identical to i_sub=0.

Test Plan:
- WIDTH=8. Reset, then start with a=0x01, b=0x01, cin=0 → o_busy high 8 cycles, o_done pulse in the cycle after edge T0+8, o_sum=0x02, o_carry=0.
- a=0xFF, b=0x01, cin=0 → o_sum=0x00, o_carry=1. Then a=0xFF, b=0xFF, cin=1 → o_sum=0xFF, o_carry=1.
- Start a=0x3C, b=0x0F. Pulse i_start with a=0xAA, b=0x55 at cycle 3 of RUN → that start is ignored; o_sum=0x4B, o_carry=0; exactly one o_done.
- Start a=0x12, b=0x34, assert i_reset at RUN cycle 4 → no o_done; o_sum=0x00, o_carry=0, o_busy=0 next cycle. A new start then gives correct 0x46.
- Back-to-back: 0x80+0x80 then 0x7F+0x01, second start at T0+10 → 0x00/carry 1, then 0x80/carry 0. Hold o_sum stable between completions.
- SERIAL_ADDER_SUB_EN defined: i_sub=1, a=0x05, b=0x07, cin=1 → o_sum=0xFE, o_carry=0. a=0x07, b=0x05, cin=1 → o_sum=0x02, o_carry=1.
